// File: rtl/fc_layer_ctrl.sv
// Fully-connected layer controller: walks addr/sel/grp counters, drives feature/weight
// read addresses (2-cycle pipeline) and delay-aligned mac_en/clr/o_wr_en/done strobes.
module fc_layer_ctrl #(
    parameter int BANK_DEPTH = 25,
    parameter int N_BANK     = 16,
    parameter int N_GRP      = 1,
    parameter int MAC_DLY    = 4,
    parameter int CLR_DLY    = 5,
    parameter int WR_DLY     = 9,
    localparam int AW = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1,
    localparam int SW = (N_BANK > 1) ? $clog2(N_BANK) : 1,
    localparam int WW = (BANK_DEPTH*N_BANK*N_GRP > 1) ? $clog2(BANK_DEPTH*N_BANK*N_GRP) : 1,
    localparam int GW = (N_GRP > 1) ? $clog2(N_GRP) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stall,
    input  logic          abort,
    output logic [AW-1:0] f_raddr,
    output logic [SW-1:0] f_sel,
    output logic [WW-1:0] w_raddr,
    output logic          mac_en,
    output logic          clr,
    output logic          o_wr_en,
    output logic [GW-1:0] o_waddr,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        RUN   = 3'b010,
        DRAIN = 3'b100
    } state_t;

    localparam logic [AW-1:0] A_LAST = AW'(BANK_DEPTH - 1);
    localparam logic [SW-1:0] S_LAST = SW'(N_BANK - 1);
    localparam logic [GW-1:0] G_LAST = GW'(N_GRP - 1);

    state_t r_state, w_next;

    logic [AW-1:0] r_addr;
    logic [SW-1:0] r_sel;
    logic [GW-1:0] r_grp;

    logic w_issue, w_grp_start, w_grp_end, w_last;
    logic [GW-1:0] w_wr_grp;

    logic [MAC_DLY-1:0]         r_mac_pipe;
    logic [CLR_DLY-1:0]         r_clr_pipe;
    logic [WR_DLY-1:0]          r_wr_pipe;
    logic [WR_DLY-1:0][GW-1:0]  r_wg_pipe;
    logic [WR_DLY:0]            r_done_pipe;
    logic                       r_s1_vld;

    logic [WW-1:0] r_s1_base, r_s1_goff, r_w_raddr;
    logic [AW-1:0] r_s1_addr, r_f_raddr;
    logic [SW-1:0] r_s1_sel, r_f_sel;

    assign w_issue     = (r_state == RUN) && !stall;
    assign w_grp_start = w_issue && (r_addr == '0) && (r_sel == '0);
    assign w_grp_end   = w_issue && (r_addr == A_LAST) && (r_sel == S_LAST);
    assign w_last      = w_grp_end && (r_grp == G_LAST);
    assign w_wr_grp    = w_grp_end ? r_grp : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start)  w_next = RUN;
                RUN:     if (w_last) w_next = DRAIN;
                DRAIN:   if (done)   w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // Counters and strobe delay lines; abort wipes everything still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_sel       <= '0;
            r_grp       <= '0;
            r_mac_pipe  <= '0;
            r_clr_pipe  <= '0;
            r_wr_pipe   <= '0;
            r_wg_pipe   <= '0;
            r_done_pipe <= '0;
            r_s1_vld    <= 1'b0;
        end else if (abort) begin
            r_addr      <= '0;
            r_sel       <= '0;
            r_grp       <= '0;
            r_mac_pipe  <= '0;
            r_clr_pipe  <= '0;
            r_wr_pipe   <= '0;
            r_wg_pipe   <= '0;
            r_done_pipe <= '0;
            r_s1_vld    <= 1'b0;
        end else begin
            r_mac_pipe  <= {r_mac_pipe[MAC_DLY-2:0], w_issue};
            r_clr_pipe  <= {r_clr_pipe[CLR_DLY-2:0], w_grp_start};
            r_wr_pipe   <= {r_wr_pipe[WR_DLY-2:0], w_grp_end};
            r_wg_pipe   <= {r_wg_pipe[WR_DLY-2:0], w_wr_grp};
            r_done_pipe <= {r_done_pipe[WR_DLY-1:0], w_last};
            r_s1_vld    <= w_issue;
            if (w_issue) begin
                if (r_addr == A_LAST) begin
                    r_addr <= '0;
                    if (r_sel == S_LAST) begin
                        r_sel <= '0;
                        r_grp <= (r_grp == G_LAST) ? '0 : r_grp + 1'b1;
                    end else begin
                        r_sel <= r_sel + 1'b1;
                    end
                end else begin
                    r_addr <= r_addr + 1'b1;
                end
            end
        end
    end

    // Weight address split: stage 1 forms the two partial products, stage 2 adds them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_base <= '0;
            r_s1_goff <= '0;
            r_s1_addr <= '0;
            r_s1_sel  <= '0;
            r_w_raddr <= '0;
            r_f_raddr <= '0;
            r_f_sel   <= '0;
        end else begin
            if (w_issue) begin
                r_s1_base <= WW'(r_addr) + WW'(r_sel) * WW'(BANK_DEPTH);
                r_s1_goff <= WW'(r_grp) * WW'(BANK_DEPTH * N_BANK);
                r_s1_addr <= r_addr;
                r_s1_sel  <= r_sel;
            end
            if (r_s1_vld) begin
                r_w_raddr <= r_s1_base + r_s1_goff;
                r_f_raddr <= r_s1_addr;
                r_f_sel   <= r_s1_sel;
            end
        end
    end

    assign f_raddr = r_f_raddr;
    assign f_sel   = r_f_sel;
    assign w_raddr = r_w_raddr;
    assign mac_en  = r_mac_pipe[MAC_DLY-1];
    assign clr     = r_clr_pipe[CLR_DLY-1];
    assign o_wr_en = r_wr_pipe[WR_DLY-1];
    assign o_waddr = r_wg_pipe[WR_DLY-1];
    assign done    = r_done_pipe[WR_DLY];
    assign busy    = (r_state != IDLE);

endmodule
